// File: rtl/tiny_alu_pkg.sv
// Shared types and constants for the tiny_alu block: opcodes, widths, FSM states.
package tiny_alu_pkg;

    localparam int DATA_W = 8;
    localparam int RES_W  = 16;

    typedef enum logic [2:0] {
        NO_OP = 3'd0,
        ADD   = 3'd1,
        AND   = 3'd2,
        XOR   = 3'd3,
        MUL   = 3'd4,
        SUB   = 3'd5,
        RST   = 3'd7
    } op_e;

    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/tiny_alu_mul.sv
// Pipelined unsigned 8x8 multiplier; the product and its valid strobe emerge
// MUL_LATENCY edges after i_vld is sampled.
module tiny_alu_mul
    import tiny_alu_pkg::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_vld,
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    output logic              o_vld,
    output logic [RES_W-1:0]  o_p
);

    logic [MUL_LATENCY-1:0] r_vld;
    logic [RES_W-1:0]       r_p [MUL_LATENCY];

    // Stage 0 forms the product; later stages only delay it alongside its valid bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vld <= '0;
            for (int i = 0; i < MUL_LATENCY; i++) begin
                r_p[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_vld;
            r_p[0]   <= {8'b0, i_a} * {8'b0, i_b};
            for (int i = 1; i < MUL_LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_p[i]   <= r_p[i-1];
            end
        end
    end

    assign o_vld = r_vld[MUL_LATENCY-1];
    assign o_p   = r_p[MUL_LATENCY-1];

endmodule

// File: rtl/tiny_alu.sv
// 8-bit ALU with start/done handshake: single-cycle add/and/xor, multi-cycle mul.
// Optional macro TINYALU_SUB_EN enables op 5 as a single-cycle subtract.
module tiny_alu
    import tiny_alu_pkg::*;
#(
    parameter int MUL_LATENCY = 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [2:0]        op,
    input  logic              start,
    output logic              done,
    output logic [RES_W-1:0]  result
);

    localparam logic [2:0] CNT_INIT = 3'(MUL_LATENCY - 1);

    state_e             r_state;
    state_e             w_state_nxt;
    logic [2:0]         r_cnt;
    logic               r_done;
    logic [RES_W-1:0]   r_result;
    logic               w_done_nxt;
    logic [RES_W-1:0]   w_res_nxt;
    logic               w_mul_start;
    logic               w_mul_vld;
    logic [RES_W-1:0]   w_mul_p;
    logic [DATA_W:0]    w_sum;
    op_e                w_op;

    assign w_op  = op_e'(op);
    assign w_sum = {1'b0, A} + {1'b0, B};

    tiny_alu_mul #(
        .MUL_LATENCY (MUL_LATENCY)
    ) u_mul (
        .clk     (clk),
        .reset_n (reset_n),
        .i_vld   (w_mul_start),
        .i_a     (A),
        .i_b     (B),
        .o_vld   (w_mul_vld),
        .o_p     (w_mul_p)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_res_nxt   = r_result;
        w_done_nxt  = 1'b0;
        w_mul_start = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    case (w_op)
                        ADD: begin
                            w_res_nxt  = {7'b0, w_sum};
                            w_done_nxt = 1'b1;
                        end
                        AND: begin
                            w_res_nxt  = {8'b0, A & B};
                            w_done_nxt = 1'b1;
                        end
                        XOR: begin
                            w_res_nxt  = {8'b0, A ^ B};
                            w_done_nxt = 1'b1;
                        end
                        MUL: begin
                            w_mul_start = 1'b1;
                            w_state_nxt = MUL_BUSY;
                        end
`ifdef TINYALU_SUB_EN
                        SUB: begin
                            w_res_nxt  = {8'b0, A} - {8'b0, B};
                            w_done_nxt = 1'b1;
                        end
`endif
                        RST: begin
                            w_res_nxt = '0;
                        end
                        default: begin
                        end
                    endcase
                end
            end
            MUL_BUSY: begin
                // Counter paces the FSM; the multiplier's valid strobe qualifies the result.
                if (r_cnt == 3'd0) begin
                    w_state_nxt = IDLE;
                end
                if (w_mul_vld) begin
                    w_res_nxt  = w_mul_p;
                    w_done_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_cnt    <= 3'd0;
            r_done   <= 1'b0;
            r_result <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_done   <= w_done_nxt;
            r_result <= w_res_nxt;
            if (w_mul_start) begin
                r_cnt <= CNT_INIT;
            end else if (r_state == MUL_BUSY && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    assign done   = r_done;
    assign result = r_result;

endmodule

// File: tb/tb_tiny_alu.sv
// Directed, table-driven bench for tiny_alu with hand-computed expectations.
module tb_tiny_alu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [2:0]  op;
    logic        start;
    logic        done;
    logic [15:0] result;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        logic [2:0]  op;
        logic [7:0]  a;
        logic [7:0]  b;
        logic        done;
        logic [15:0] res;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl [NV];

    tiny_alu #(.MUL_LATENCY(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .A       (A),
        .B       (B),
        .op      (op),
        .start   (start),
        .done    (done),
        .result  (result)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required<200000", $time);
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    initial begin
        tbl[0]  = '{3'd1, 8'hFF, 8'h01, 1'b1, 16'h0100};
        tbl[1]  = '{3'd2, 8'hF0, 8'h3C, 1'b1, 16'h0030};
        tbl[2]  = '{3'd3, 8'hAA, 8'hFF, 1'b1, 16'h0055};
        tbl[3]  = '{3'd1, 8'h03, 8'h04, 1'b1, 16'h0007};
        tbl[4]  = '{3'd1, 8'h80, 8'h80, 1'b1, 16'h0100};
        tbl[5]  = '{3'd0, 8'h05, 8'h07, 1'b0, 16'h0100};
        tbl[6]  = '{3'd6, 8'h12, 8'h34, 1'b0, 16'h0100};
`ifdef TINYALU_SUB_EN
        tbl[7]  = '{3'd5, 8'h03, 8'h05, 1'b1, 16'hFFFE};
`else
        tbl[7]  = '{3'd5, 8'h03, 8'h05, 1'b0, 16'h0100};
`endif
        tbl[8]  = '{3'd1, 8'h10, 8'h20, 1'b1, 16'h0030};
        tbl[9]  = '{3'd7, 8'h00, 8'h00, 1'b0, 16'h0000};
        tbl[10] = '{3'd3, 8'h00, 8'h00, 1'b1, 16'h0000};
        tbl[11] = '{3'd2, 8'hFF, 8'hFF, 1'b1, 16'h00FF};

        A = 8'h00; B = 8'h00; op = 3'd0; start = 1'b0;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) step();
        check("reset_result", result, 16'h0000);
        check("reset_done", {15'b0, done}, 16'h0000);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            step();
            check("idle_result", result, 16'h0000);
            check("idle_done", {15'b0, done}, 16'h0000);
        end

        // Back-to-back commands with start held high.
        start = 1'b1;
        for (int i = 0; i < NV; i++) begin
            op = tbl[i].op; A = tbl[i].a; B = tbl[i].b;
            step();
            check($sformatf("vec%0d_done", i), {15'b0, done}, {15'b0, tbl[i].done});
            check($sformatf("vec%0d_result", i), result, tbl[i].res);
        end
        start = 1'b0;
        step();
        check("post_loop_done", {15'b0, done}, 16'h0000);
        check("post_loop_result", result, 16'h00FF);

        // Multiply with start held; operands changed while busy must be ignored.
        op = 3'd4; A = 8'hFF; B = 8'hFF; start = 1'b1;
        step();
        check("mul_e0_done", {15'b0, done}, 16'h0000);
        op = 3'd1; A = 8'h01; B = 8'h02;
        step();
        check("mul_e1_done", {15'b0, done}, 16'h0000);
        check("mul_e1_result", result, 16'h00FF);
        step();
        check("mul_e2_done", {15'b0, done}, 16'h0000);
        check("mul_e2_result", result, 16'h00FF);
        step();
        check("mul_e3_done", {15'b0, done}, 16'h0001);
        check("mul_e3_result", result, 16'hFE01);
        step();
        check("mul_next_done", {15'b0, done}, 16'h0001);
        check("mul_next_result", result, 16'h0003);
        start = 1'b0;
        step();
        check("mul_idle_done", {15'b0, done}, 16'h0000);

        // rst_op after a multiply result.
        op = 3'd4; A = 8'hFF; B = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        check("mul2_done", {15'b0, done}, 16'h0001);
        check("mul2_result", result, 16'hFE01);
        op = 3'd7; start = 1'b1;
        step();
        start = 1'b0;
        check("rstop_result", result, 16'h0000);
        check("rstop_done", {15'b0, done}, 16'h0000);

        // Asynchronous reset clears outputs without a clock edge.
        op = 3'd1; A = 8'hFF; B = 8'h01; start = 1'b1;
        step();
        start = 1'b0;
        check("pre_async_done", {15'b0, done}, 16'h0001);
        check("pre_async_result", result, 16'h0100);
        reset_n = 1'b0;
        #1;
        check("async_result", result, 16'h0000);
        check("async_done", {15'b0, done}, 16'h0000);
        #2 reset_n = 1'b1;

        // Reset during a multiply aborts it.
        op = 3'd4; A = 8'h10; B = 8'h10; start = 1'b1;
        step();
        start = 1'b0;
        step();
        reset_n = 1'b0;
        #1;
        check("mulrst_result", result, 16'h0000);
        #2 reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("mulrst_nodone", {15'b0, done}, 16'h0000);
            check("mulrst_hold", result, 16'h0000);
        end
        op = 3'd1; A = 8'h03; B = 8'h04; start = 1'b1;
        step();
        start = 1'b0;
        check("after_rst_add_done", {15'b0, done}, 16'h0001);
        check("after_rst_add_result", result, 16'h0007);
        step();
        check("after_rst_add_pulse", {15'b0, done}, 16'h0000);
        check("after_rst_add_hold", result, 16'h0007);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/tiny_alu.md
Name: tiny_alu

Overview:
- Small 8-bit arithmetic/logic unit with a start/done handshake.
- Single-cycle ops: add, and, xor. Multi-cycle op: unsigned multiply, 3 cycles by default.
- Sits behind a command driver that presents A, B and op with start, and collects a 16-bit result when done pulses.

Parameters:
- MUL_LATENCY, 3: clock edges from multiply acceptance to done; legal range 1..8.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- A  input  8  operand A, unsigned.
- B  input  8  operand B, unsigned.
- op  input  3  opcode: 0 no_op, 1 add, 2 and, 3 xor, 4 mul, 7 rst_op, 5/6 reserved.
- start  input  1  command valid.
- done  output  1  one-cycle completion pulse.
- result  output  16  operation result; held between completions.

Behaviour:
- Clocking: one clock (clk). Reset reset_n is asynchronous and active-low.
- Reset values: result=0, done=0, FSM=IDLE, multiplier pipeline cleared.
  - Reset asserted mid-multiply aborts the operation; no done is produced.
- States: IDLE, MUL_BUSY (with a down-counter).
- Acceptance: a command is accepted on a rising edge where start=1 and FSM=IDLE. A, B and op are sampled at that edge. Inputs are ignored while MUL_BUSY.
- Single-cycle ops (add/and/xor), accepted at edge N:
  - result and done=1 are registered at edge N.
  - Visible in the cycle following N.
  - FSM stays IDLE, so start held high gives one result per cycle.
- Arithmetic:
  - add: result = {7'b0, A+B}, 9-bit sum, carry kept in bit 8.
  - and: {8'b0, A&B}.
  - xor: {8'b0, A^B}.
- mul, accepted at edge N:
  - Operands are latched and FSM enters MUL_BUSY.
  - At edge N+MUL_LATENCY: result = A*B (full 16-bit unsigned), done=1, FSM returns to IDLE.
  - Earliest next acceptance is edge N+MUL_LATENCY+1.
- no_op and reserved codes: accepted, no done, result unchanged.
- rst_op (7): result cleared to 0 at the accepting edge, no done, FSM stays IDLE.
- done is high for exactly one cycle per completing command. It is 0 in every cycle without a completion.
- Commands are never queued. start must be held or re-presented to issue the next command.

Optional Feature:
- Macro TINYALU_SUB_EN.
- Defined: op 5 = subtract, single-cycle. result = {8{borrow}, (A-B)[7:0]}, i.e. the 16-bit two's-complement difference of zero-extended A and B. done follows single-cycle timing.
- Undefined: op 5 is reserved and behaves as no_op.

Decomposition:
- Package tiny_alu_pkg:
  - op enumeration (NO_OP, ADD, AND, XOR, MUL, SUB, RST).
  - Constants DATA_W=8 and RES_W=16.
  - FSM state typedef.
- Sub-module tiny_alu_mul:
  - Pipelined unsigned 8x8 multiplier, MUL_LATENCY stages.
  - Has a valid-in/valid-out strobe; the top uses valid-out to generate done.
- Top module tiny_alu contains the handshake FSM, the single-cycle datapath and the result register.

Test Plan:
- Reset then idle, start=0 -> result=16'h0000, done=0 for 10 cycles; assert reset_n=0 mid-run -> result and done clear immediately without a clock edge.
- add A=8'hFF B=8'h01 -> next cycle done=1, result=16'h0100; and A=8'hF0 B=8'h3C -> 16'h0030; xor A=8'hAA B=8'hFF -> 16'h0055.
- mul A=8'hFF B=8'hFF, start held high -> done exactly 3 edges after acceptance with result=16'hFE01; operand changes during busy are ignored; next acceptance occurs one edge after done.
- Back-to-back add commands with start held high and new operands each cycle -> one done pulse per cycle, results in issue order; no_op A=5 B=7 -> no done, result unchanged.
- rst_op after a mul result 16'hFE01 -> result=16'h0000, done=0; reset_n pulse low during a multiply -> no done, and the next add 3+4 yields 16'h0007.
- TINYALU_SUB_EN defined: sub A=8'h03 B=8'h05 -> result=16'hFFFE, done=1 after one cycle; macro undefined: same stimulus -> no done, result unchanged.
